calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Sequences one calculator transaction for the UART warm-up design.
- Takes a complete command frame (operation, operand A, operand B) from the UART receive/frame-assembly stage.
- Launches the shared ALU with a start/done handshake and captures the 16-bit result.
- Returns the result to the host through the UART transmitter, MSB byte first.
- Sits between the receive-side command registers and the ALU and UART TX.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles to wait for alu_done after alu_start; range 2..65535.
MAX_OPCODE, 8'h07, highest legal opcode; larger opcodes are rejected without touching the ALU.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  one-cycle pulse: operation/data_a/data_b hold a new frame
operation  in  8  opcode of frame
data_a  in  8  operand A
data_b  in  8  operand B
cmd_ready  out  1  high only in IDLE (decoded from state; high during reset)
alu_start  out  1  registered one-cycle launch pulse
alu_op  out  8  latched opcode, stable from alu_start until back in IDLE
alu_a  out  8  latched operand A
alu_b  out  8  latched operand B
alu_done  in  1  one-cycle pulse, alu_result valid
alu_result  in  16  ALU result
tx_start  out  1  registered one-cycle pulse to UART TX
tx_data  out  8  byte to send, stable while tx_start is high
tx_busy  in  1  UART TX busy; contract: asserted by the cycle after tx_start
busy  out  1  high in any state other than IDLE
error  out  1  sticky: timeout occurred
overrun  out  1  sticky: cmd_valid arrived while not IDLE

Behaviour:
- Reset (async, any state): state goes to IDLE. alu_start, tx_start, alu_op, alu_a, alu_b, tx_data, busy, error and overrun all go to 0. The timer, byte counter and result register clear.
- States and transitions:
  - IDLE: on cmd_valid, latch operation/data_a/data_b into alu_op/alu_a/alu_b. If operation > MAX_OPCODE, load response byte 8'hEE and go to SEND with a 1-byte response. Otherwise go to LAUNCH.
  - LAUNCH: alu_start=1 for exactly 1 cycle; clear timer; go to WAIT_ALU.
  - WAIT_ALU: on alu_done, capture alu_result and go to SEND with a 2-byte response. Otherwise increment the timer. When the timer reaches TIMEOUT_CYCLES-1, set error, load 8'hEF and go to SEND with a 1-byte response.
  - WAIT_ALU tie-break: if alu_done and timeout occur in the same cycle, done wins and error stays 0.
  - SEND: wait while tx_busy=1. When tx_busy=0, pulse tx_start for 1 cycle with tx_data set to the current byte, then go to GAP.
  - GAP: one cycle, letting tx_busy rise; go to WAIT_TX.
  - WAIT_TX: when tx_busy=0, either advance the byte counter and return to SEND, or go to IDLE after the last byte.
- Byte order: result[15:8] first, then result[7:0].
- Latency: alu_start follows cmd_valid by 2 cycles (IDLE→LAUNCH registered). The first tx_start follows alu_done by 2 cycles if tx_busy=0.
- cmd_valid outside IDLE: the frame is dropped and overrun is set; the transaction in flight is unaffected.
- cmd_valid in the same cycle the FSM returns to IDLE: not accepted (cmd_ready was 0); overrun is set.
- alu_done outside WAIT_ALU: ignored.
- Timer width: 16 bits; it never wraps because it is bounded by TIMEOUT_CYCLES.
- error and overrun clear only on reset.

Optional Feature:
Macro CALC_SEQ_CHECKSUM_EN.
- Defined: every response gets one extra trailing byte, the XOR of all preceding response bytes. Normal results send 3 bytes; the 8'hEE and 8'hEF error responses send 2 bytes (code, then code again as its checksum).
- Undefined: no checksum byte; responses are 2 or 1 bytes as described above.

Test Plan:
- Normal add: op=8'h01, a=8'h12, b=8'h34; ALU model returns 16'h0046 three cycles after alu_start → exactly one alu_start; tx bytes 8'h00 then 8'h46; busy falls after the second byte; error=0.
- Illegal opcode: op=8'h09 → no alu_start; single tx byte 8'hEE; back to IDLE; error=0.
- Timeout: TIMEOUT_CYCLES=16, ALU never asserts done → tx byte 8'hEF exactly 16 cycles after alu_start; error=1 until reset.
- TX backpressure: tx_busy held high for 50 cycles before the first send → tx_start withheld until tx_busy=0; tx_data stable; both bytes still sent in order.
- Overrun, then reset: cmd_valid pulse during WAIT_ALU → overrun=1 and the transaction completes normally. Then assert reset mid-GAP → all outputs 0 immediately; cmd_ready=1 after release.
- With CALC_SEQ_CHECKSUM_EN: result 16'h1234 → tx bytes 8'h12, 8'h34, 8'h26.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Calculator sequencer bus: command frame in, ALU start/done, UART TX handshake, status.
// master = the sequencer itself, slave = the surrounding receive/ALU/TX logic.
interface calc_sequencer_if;
  logic        cmd_valid;
  logic [7:0]  operation;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        cmd_ready;
  logic        alu_start;
  logic [7:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy;
  logic        error;
  logic        overrun;

  modport master (
    input  cmd_valid, operation, data_a, data_b, alu_done, alu_result, tx_busy,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b, tx_start, tx_data, busy, error, overrun
  );

  modport slave (
    output cmd_valid, operation, data_a, data_b, alu_done, alu_result, tx_busy,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b, tx_start, tx_data, busy, error, overrun
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences one calculator transaction: accept frame, run ALU, send result MSB first.
// Optional macro CALC_SEQ_CHECKSUM_EN appends an XOR checksum byte to every response.
module calc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  MAX_OPCODE     = 8'h07
) (
  input logic              clk,
  input logic              reset,
  calc_sequencer_if.master bus
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_W-1:0]  RSP_BAD_OP = 8'hEE;
  localparam logic [BYTE_W-1:0]  RSP_TMO    = 8'hEF;
`ifdef CALC_SEQ_CHECKSUM_EN
  localparam logic [CNT_W-1:0] EXTRA_BYTES = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] EXTRA_BYTES = CNT_W'(0);
`endif

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ALU, SEND, GAP, WAIT_TX} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   op_q, op_d, a_q, a_d, b_q, b_d;
  logic                alu_start_q, alu_start_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*BYTE_W-1:0] result_q, result_d;
  logic                short_q, short_d;
  logic                error_q, error_d;
  logic                overrun_q, overrun_d;
  logic [BYTE_W-1:0]   cur_byte_c;
  logic [CNT_W-1:0]    last_idx_c;
  logic [TIMER_W-1:0]  timer_inc_c;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_start = alu_start_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.error     = error_q;
  assign bus.overrun   = overrun_q;

  // Byte selection: short responses carry only the code in result_q[15:8]
  always_comb begin
    timer_inc_c = timer_q + TIMER_W'(1);
    last_idx_c  = (short_q ? CNT_W'(0) : CNT_W'(1)) + EXTRA_BYTES;
    if (cnt_q == CNT_W'(0)) begin
      cur_byte_c = result_q[15:8];
    end else if (cnt_q == CNT_W'(1) && !short_q) begin
      cur_byte_c = result_q[7:0];
    end else begin
      cur_byte_c = result_q[15:8] ^ (short_q ? BYTE_W'(0) : result_q[7:0]);
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_start_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    short_d     = short_q;
    error_d     = error_q;
    overrun_d   = overrun_q | (bus.cmd_valid & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.operation;
          a_d   = bus.data_a;
          b_d   = bus.data_b;
          cnt_d = CNT_W'(0);
          if (bus.operation > MAX_OPCODE) begin
            result_d = {RSP_BAD_OP, BYTE_W'(0)};
            short_d  = 1'b1;
            state_d  = SEND;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        alu_start_d = 1'b1;
        timer_d     = TIMER_W'(0);
        state_d     = WAIT_ALU;
      end
      WAIT_ALU: begin
        // done has priority over a timeout landing in the same cycle
        if (bus.alu_done) begin
          result_d = bus.alu_result;
          short_d  = 1'b0;
          state_d  = SEND;
        end else if (timer_inc_c == TIMER_LAST) begin
          error_d  = 1'b1;
          result_d = {RSP_TMO, BYTE_W'(0)};
          short_d  = 1'b1;
          state_d  = SEND;
        end else begin
          timer_d = timer_inc_c;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte_c;
          state_d    = GAP;
        end
      end
      GAP: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (!bus.tx_busy) begin
          if (cnt_q == last_idx_c) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      short_q     <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_start_q <= alu_start_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      short_q     <= short_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: ALU and UART TX responders plus a response-byte model.
module tb_calc_sequencer;

  logic clk;
  logic reset;
  logic tx_busy_resp;
  logic tx_hold;
  int   alu_lat;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_alu_start;
  int   alu_start_cyc;
  int   done_cyc;
  int   tx_first_cyc;
  int   cmd_cyc;

  logic [23:0] exp_alu[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];

`ifdef CALC_SEQ_CHECKSUM_EN
  localparam int NB_OK  = 3;
  localparam int NB_ERR = 2;
`else
  localparam int NB_OK  = 2;
  localparam int NB_ERR = 1;
`endif

  calc_sequencer_if bus ();

  calc_sequencer #(.TIMEOUT_CYCLES(16), .MAX_OPCODE(8'h07)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.tx_busy = tx_busy_resp | tx_hold;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ALU behaviour the bench assumes
  function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      8'h01:   return 16'(a) + 16'(b);
      8'h02:   return 16'(a) - 16'(b);
      8'h04:   return {a, b};
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Response model: bytes the host must receive, in order
  task automatic push_resp(input bit is_err, input logic [7:0] code, input logic [15:0] r);
    if (is_err) begin
      exp_tx.push_back(code);
`ifdef CALC_SEQ_CHECKSUM_EN
      exp_tx.push_back(code);
`endif
    end else begin
      exp_tx.push_back(r[15:8]);
      exp_tx.push_back(r[7:0]);
`ifdef CALC_SEQ_CHECKSUM_EN
      exp_tx.push_back(r[15:8] ^ r[7:0]);
`endif
    end
  endtask

  task automatic expect_ok(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_alu.push_back({op, a, b});
    push_resp(1'b0, 8'h00, alu_fn(op, a, b));
  endtask

  // ALU responder: done alu_lat cycles after alu_start, never when alu_lat < 0
  initial begin
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.alu_start && alu_lat >= 0) begin
        repeat (alu_lat) @(posedge clk);
        #1;
        bus.alu_done   = 1'b1;
        bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        done_cyc       = cyc;
        @(posedge clk);
        #1;
        bus.alu_done = 1'b0;
      end
    end
  end

  // UART TX responder: busy from the cycle after tx_start for four cycles
  initial begin
    tx_busy_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        @(posedge clk);
        #1 tx_busy_resp = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_busy_resp = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic       prev_busy;
    logic [23:0] f;
    logic [7:0]  eb;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
        if (bus.alu_start) begin
          n_alu_start++;
          alu_start_cyc = cyc;
          if (exp_alu.size() == 0) begin
            fail_now("alu_start_unexpected");
          end else begin
            f = exp_alu.pop_front();
            check("alu_op", 32'(bus.alu_op), 32'(f[23:16]));
            check("alu_a",  32'(bus.alu_a),  32'(f[15:8]));
            check("alu_b",  32'(bus.alu_b),  32'(f[7:0]));
          end
        end
        if (bus.tx_start) begin
          if (tx_log.size() == 0) tx_first_cyc = cyc;
          tx_log.push_back(bus.tx_data);
          check("tx_start_while_busy", 32'(prev_busy), 32'(0));
          if (exp_tx.size() == 0) begin
            fail_now("tx_byte_unexpected");
          end else begin
            eb = exp_tx.pop_front();
            check("tx_byte", 32'(bus.tx_data), 32'(eb));
          end
        end
      end
      prev_busy = bus.tx_busy;
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.cmd_ready) fail_now("cmd_ready_timeout");
    bus.cmd_valid = 1'b1;
    bus.operation = op;
    bus.data_a    = a;
    bus.data_b    = b;
    cmd_cyc       = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((bus.busy || exp_tx.size() != 0) && k < budget);
    if (bus.busy || exp_tx.size() != 0) fail_now("idle_timeout");
  endtask

  initial begin
    int         a0;
    int         k;
    logic [7:0] td0;
    n_tests = 0; n_fail = 0; n_alu_start = 0;
    alu_start_cyc = 0; done_cyc = 0; tx_first_cyc = 0; cmd_cyc = 0;
    alu_lat = 3; tx_hold = 1'b0; reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.operation = '0; bus.data_a = '0; bus.data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    check("rst_busy",      32'(bus.busy),      32'(0));
    check("rst_error",     32'(bus.error),     32'(0));
    check("rst_tx_data",   32'(bus.tx_data),   32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal add 0x12 + 0x34 = 0x0046
    tx_log.delete();
    a0 = n_alu_start;
    expect_ok(8'h01, 8'h12, 8'h34);
    send_cmd(8'h01, 8'h12, 8'h34);
    wait_idle(200);
    check("add_alu_starts",   32'(n_alu_start - a0),       32'(1));
    check("add_start_lat",    32'(alu_start_cyc - cmd_cyc), 32'(2));
    check("add_tx_lat",       32'(tx_first_cyc - done_cyc), 32'(2));
    check("add_nbytes",       32'(tx_log.size()),          32'(NB_OK));
    check("add_byte0",        32'(tx_log[0]),              32'h00);
    check("add_byte1",        32'(tx_log[1]),              32'h46);
    check("add_error",        32'(bus.error),              32'(0));

    // Illegal opcode: no ALU launch, single 0xEE
    tx_log.delete();
    a0 = n_alu_start;
    push_resp(1'b1, 8'hEE, 16'h0);
    send_cmd(8'h09, 8'h01, 8'h02);
    wait_idle(200);
    check("bad_alu_starts", 32'(n_alu_start - a0), 32'(0));
    check("bad_nbytes",     32'(tx_log.size()),    32'(NB_ERR));
    check("bad_byte0",      32'(tx_log[0]),        32'hEE);
    check("bad_error",      32'(bus.error),        32'(0));
    check("bad_ready",      32'(bus.cmd_ready),    32'(1));

    // Timeout: ALU silent, 0xEF lands 16 cycles after alu_start
    tx_log.delete();
    alu_lat = -1;
    exp_alu.push_back({8'h02, 8'h05, 8'h06});
    push_resp(1'b1, 8'hEF, 16'h0);
    send_cmd(8'h02, 8'h05, 8'h06);
    wait_idle(200);
    alu_lat = 3;
    check("tmo_lat",    32'(tx_first_cyc - alu_start_cyc), 32'(16));
    check("tmo_byte0",  32'(tx_log[0]),                    32'hEF);
    check("tmo_nbytes", 32'(tx_log.size()),                32'(NB_ERR));
    check("tmo_error",  32'(bus.error),                    32'(1));

    // Subtraction with and without borrow; error stays sticky
    tx_log.delete();
    expect_ok(8'h02, 8'h50, 8'h08);
    send_cmd(8'h02, 8'h50, 8'h08);
    wait_idle(200);
    expect_ok(8'h02, 8'h08, 8'h50);
    send_cmd(8'h02, 8'h08, 8'h50);
    wait_idle(200);
    check("sub_byte1",    32'(tx_log[1]),      32'h48);
    check("sub_b_byte0",  32'(tx_log[NB_OK]),  32'hFF);
    check("sub_b_byte1",  32'(tx_log[NB_OK+1]), 32'hB8);
    check("sticky_error", 32'(bus.error),      32'(1));

    // TX backpressure: tx_busy held high for 50 cycles
    tx_log.delete();
    tx_hold = 1'b1;
    td0 = bus.tx_data;
    expect_ok(8'h04, 8'hAB, 8'hCD);
    send_cmd(8'h04, 8'hAB, 8'hCD);
    repeat (50) @(posedge clk);
    #1;
    check("bp_no_tx",   32'(tx_log.size()), 32'(0));
    check("bp_tx_data", 32'(bus.tx_data),   32'(td0));
    check("bp_busy",    32'(bus.busy),      32'(1));
    tx_hold = 1'b0;
    wait_idle(200);
    check("bp_byte0", 32'(tx_log[0]), 32'hAB);
    check("bp_byte1", 32'(tx_log[1]), 32'hCD);

    // Overrun during WAIT_ALU: frame dropped, transaction unaffected
    tx_log.delete();
    alu_lat = 6;
    a0 = n_alu_start;
    check("pre_overrun", 32'(bus.overrun), 32'(0));
    expect_ok(8'h01, 8'h20, 8'h22);
    send_cmd(8'h01, 8'h20, 8'h22);
    k = 0;
    while (n_alu_start == a0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_alu_start == a0) fail_now("ovr_alu_start_timeout");
    bus.cmd_valid = 1'b1;
    bus.operation = 8'h03;
    bus.data_a    = 8'h77;
    bus.data_b    = 8'h99;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    alu_lat = 3;
    check("ovr_flag",       32'(bus.overrun),      32'(1));
    check("ovr_alu_starts", 32'(n_alu_start - a0), 32'(1));
    check("ovr_byte1",      32'(tx_log[1]),        32'h42);

    // Reset asserted while in GAP (the tx_start cycle)
    expect_ok(8'h01, 8'h01, 8'h02);
    send_cmd(8'h01, 8'h01, 8'h02);
    k = 0;
    while (!bus.tx_start && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.tx_start) fail_now("gap_wait_timeout");
    #1 reset = 1'b1;
    #1;
    check("mr_busy",      32'(bus.busy),      32'(0));
    check("mr_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    check("mr_tx_start",  32'(bus.tx_start),  32'(0));
    check("mr_alu_start", 32'(bus.alu_start), 32'(0));
    check("mr_alu_op",    32'(bus.alu_op),    32'(0));
    check("mr_alu_a",     32'(bus.alu_a),     32'(0));
    check("mr_alu_b",     32'(bus.alu_b),     32'(0));
    check("mr_tx_data",   32'(bus.tx_data),   32'(0));
    check("mr_error",     32'(bus.error),     32'(0));
    check("mr_overrun",   32'(bus.overrun),   32'(0));
    exp_tx.delete();
    exp_alu.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 32'(1));

    // Result 0x1234 (checksum 0x26 when enabled)
    tx_log.delete();
    expect_ok(8'h04, 8'h12, 8'h34);
    send_cmd(8'h04, 8'h12, 8'h34);
    wait_idle(200);
    check("ck_nbytes", 32'(tx_log.size()), 32'(NB_OK));
    check("ck_byte0",  32'(tx_log[0]),     32'h12);
    check("ck_byte1",  32'(tx_log[1]),     32'h34);
`ifdef CALC_SEQ_CHECKSUM_EN
    check("ck_byte2",  32'(tx_log[2]),     32'h26);
`endif
    check("end_overrun", 32'(bus.overrun), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
